pwm_cfg_loader: RTL and testbench

//  Byte-serial configuration front-end directly upstream of the PWM core in tt_um_jhi_pwm_generator.

---
 rtl/pwm_cfg_pkg.sv | 44 ++++
 rtl/pwm_cfg_loader_if.sv | 8 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/pwm_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_pwm_cfg_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration path: FSM states, register indices,
// reset values, ctrl-byte layout and the duty clamp applied when a configuration goes live.
package pwm_cfg_pkg;

    typedef enum logic {
        IDLE,
        DATA
    } cfg_state_t;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_DUTY0  = 2'd1;
    localparam logic [1:0] REG_DUTY1  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned CTRL_CLR_ERR   = 7;
    localparam int unsigned CTRL_POL_LSB   = 2;
    localparam int unsigned CTRL_CH_EN_LSB = 0;

    typedef struct packed {
        logic [7:0] period;
        logic [7:0] duty0;
        logic [7:0] duty1;
        logic [1:0] ch_en;
        logic [1:0] polarity;
    } cfg_t;

    localparam cfg_t RST_CFG = '{
        period:   8'hFF,
        duty0:    8'h00,
        duty1:    8'h00,
        ch_en:    2'b00,
        polarity: 2'b00
    };

    // A duty larger than the period would never reach its compare point; pin it to the period.
    function automatic cfg_t clamp_cfg(input cfg_t c);
        cfg_t r;
        r = c;
        if (c.duty0 > c.period) r.duty0 = c.period;
        if (c.duty1 > c.period) r.duty1 = c.period;
        return r;
    endfunction

endpackage

// File: rtl/pwm_cfg_loader_if.sv
// Byte-serial configuration pins: data byte plus the raw asynchronous strobe that marks it.
interface pwm_cfg_loader_if;
    logic [7:0] din;
    logic       strobe_in;

    modport master (output din, output strobe_in);
    modport slave  (input  din, input  strobe_in);
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin followed by a registered rising-edge pulse.
// Pin rise to pulse is STAGES+1 clock edges.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_in};
            last_q <= sync_q[STAGES-1];
            pulse  <= sync_q[STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/pwm_cfg_loader.sv
// Two-byte (address, data) configuration loader: stages period/duty/ctrl values and
// commits them to the PWM core only on period_end so the waveform never glitches.
module pwm_cfg_loader
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  HEADER         = 4'hA,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    pwm_cfg_loader_if.slave        bus,
    input  logic                   period_end,
    output logic [7:0]             period,
    output logic [7:0]             duty0,
    output logic [7:0]             duty1,
    output logic [1:0]             ch_en,
    output logic [1:0]             polarity,
    output logic                   busy,
    output logic                   pending,
    output logic                   err
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic       byte_valid;
    cfg_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       wr_en;
    logic       set_err;
    logic       clr_err;
    cfg_t       stg_q;
    cfg_t       act_q;
    logic       pending_q;
    logic       err_q;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (bus.strobe_in),
        .pulse  (byte_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        set_err = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (byte_valid) begin
                        if (bus.din[7:4] == HEADER) begin
                            idx_d   = bus.din[1:0];
                            state_d = DATA;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign clr_err = wr_en && (idx_q == REG_CTRL) && bus.din[CTRL_CLR_ERR];

    // Commit reads the pre-write staging value, so a same-cycle write is held for the next period
    // and its pending flag takes priority over the clear from the commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_q     <= RST_CFG;
            act_q     <= RST_CFG;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (period_end && pending_q) begin
                act_q <= clamp_cfg(stg_q);
            end
            if (wr_en) begin
                unique case (idx_q)
                    REG_PERIOD: stg_q.period <= bus.din;
                    REG_DUTY0:  stg_q.duty0  <= bus.din;
                    REG_DUTY1:  stg_q.duty1  <= bus.din;
                    REG_CTRL: begin
                        stg_q.polarity <= bus.din[CTRL_POL_LSB +: 2];
                        stg_q.ch_en    <= bus.din[CTRL_CH_EN_LSB +: 2];
                    end
                    default: ;
                endcase
            end
            if (wr_en) begin
                pending_q <= 1'b1;
            end else if (period_end) begin
                pending_q <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign period   = act_q.period;
    assign duty0    = act_q.duty0;
    assign duty1    = act_q.duty1;
    assign ch_en    = act_q.ch_en;
    assign polarity = act_q.polarity;
    assign busy     = (state_q == DATA);
    assign pending  = pending_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Scoreboarded bench for pwm_cfg_loader: directed scenarios plus randomized byte traffic,
// checked against a transaction-level model of the configuration registers.
module tb_pwm_cfg_loader;

    localparam int unsigned TO   = 1024;
    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       period_end = 1'b0;
    logic [7:0] period, duty0, duty1;
    logic [1:0] ch_en, polarity;
    logic       busy, pending, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_cfg_loader_if bus ();

    pwm_cfg_loader #(
        .TIMEOUT_CYCLES (TO),
        .HEADER         (4'hA),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .bus        (bus),
        .period_end (period_end),
        .period     (period),
        .duty0      (duty0),
        .duty1      (duty1),
        .ch_en      (ch_en),
        .polarity   (polarity),
        .busy       (busy),
        .pending    (pending),
        .err        (err)
    );

    // Reference model: register file view of the loader
    logic [7:0] m_stg_p, m_stg_d0, m_stg_d1, m_act_p, m_act_d0, m_act_d1;
    logic [1:0] m_stg_en, m_stg_pol, m_act_en, m_act_pol, m_idx;
    logic       m_busy, m_pend, m_err;

    typedef struct {
        string       name;
        logic [30:0] v;
    } exp_t;
    exp_t q[$];

    function automatic void m_reset();
        m_stg_p = 8'hFF; m_stg_d0 = 8'h00; m_stg_d1 = 8'h00; m_stg_en = 2'b00; m_stg_pol = 2'b00;
        m_act_p = 8'hFF; m_act_d0 = 8'h00; m_act_d1 = 8'h00; m_act_en = 2'b00; m_act_pol = 2'b00;
        m_busy = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_idx = 2'd0;
    endfunction

    function automatic void m_step(input logic [7:0] b, input bit has_byte, input bit pe, input bit en);
        if (pe && m_pend) begin
            m_act_p   = m_stg_p;
            m_act_d0  = (m_stg_d0 > m_stg_p) ? m_stg_p : m_stg_d0;
            m_act_d1  = (m_stg_d1 > m_stg_p) ? m_stg_p : m_stg_d1;
            m_act_en  = m_stg_en;
            m_act_pol = m_stg_pol;
            m_pend    = 1'b0;
        end
        if (!en) begin
            m_busy = 1'b0;
        end else if (has_byte) begin
            if (!m_busy) begin
                if (b[7:4] == 4'hA) begin
                    m_busy = 1'b1;
                    m_idx  = b[1:0];
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                case (m_idx)
                    2'd0: m_stg_p  = b;
                    2'd1: m_stg_d0 = b;
                    2'd2: m_stg_d1 = b;
                    default: begin
                        m_stg_pol = b[3:2];
                        m_stg_en  = b[1:0];
                        if (b[7]) m_err = 1'b0;
                    end
                endcase
                m_pend = 1'b1;
                m_busy = 1'b0;
            end
        end
    endfunction

    function automatic logic [30:0] model_vec();
        return {m_act_p, m_act_d0, m_act_d1, m_act_en, m_act_pol, m_busy, m_pend, m_err};
    endfunction

    task automatic expect_state(input string name);
        exp_t e;
        e.name = name;
        e.v    = model_vec();
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe held SYNC+3 cycles; byte is consumed at edge SYNC+2, where period_end may coincide.
    task automatic send_byte(input logic [7:0] b, input bit pe);
        bus.din       = b;
        bus.strobe_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == SYNC + 1 && pe) period_end = 1'b1;
            if (k == SYNC + 2) period_end = 1'b0;
            if (k == SYNC + 3) bus.strobe_in = 1'b0;
        end
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        tick();
    endtask

    // Monitor: compares the DUT's visible state against each queued expectation
    initial begin
        exp_t        e;
        logic [30:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {period, duty0, duty1, ch_en, polarity, busy, pending, err};
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL %s: got per=%h d0=%h d1=%h en=%b pol=%b busy=%b pend=%b err=%b, expected per=%h d0=%h d1=%h en=%b pol=%b busy=%b pend=%b err=%b",
                             e.name, got[30:23], got[22:15], got[14:7], got[6:5], got[4:3], got[2], got[1], got[0],
                             e.v[30:23], e.v[22:15], e.v[14:7], e.v[6:5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        bit          pe;
        int unsigned op;

        bus.din       = 8'h00;
        bus.strobe_in = 1'b0;
        m_reset();

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        ena   = 1'b1;
        expect_state("reset");
        tick();

        // Basic writes, held until period_end
        send_byte(8'hA1, 1'b0); m_step(8'hA1, 1, 0, 1); expect_state("t2_addr_busy");
        send_byte(8'h40, 1'b0); m_step(8'h40, 1, 0, 1); expect_state("t2_duty0_staged");
        send_byte(8'hA0, 1'b0); m_step(8'hA0, 1, 0, 1);
        send_byte(8'h80, 1'b0); m_step(8'h80, 1, 0, 1); expect_state("t2_no_change_before_pe");
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t2_commit");

        // Bad header, then ctrl write with error clear
        send_byte(8'h51, 1'b0); m_step(8'h51, 1, 0, 1); expect_state("t3_bad_header");
        send_byte(8'hA3, 1'b0); m_step(8'hA3, 1, 0, 1);
        send_byte(8'h8D, 1'b0); m_step(8'h8D, 1, 0, 1); expect_state("t3_err_cleared_ctrl_held");
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t3_ctrl_commit");

        // Duty clamp against a smaller period
        send_byte(8'hA0, 1'b0); m_step(8'hA0, 1, 0, 1);
        send_byte(8'h10, 1'b0); m_step(8'h10, 1, 0, 1);
        send_byte(8'hA2, 1'b0); m_step(8'hA2, 1, 0, 1);
        send_byte(8'hF0, 1'b0); m_step(8'hF0, 1, 0, 1);
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t4_clamp");
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t4_pe_no_pending_holds");

        // Timeout between address and data byte
        send_byte(8'hA1, 1'b0); m_step(8'hA1, 1, 0, 1);
        repeat (TO - 20) tick();
        expect_state("t5_still_busy");
        repeat (20) tick();
        m_busy = 1'b0; m_err = 1'b1;
        expect_state("t5_timeout");
        tick();
        send_byte(8'hA1, 1'b0); m_step(8'hA1, 1, 0, 1);
        send_byte(8'h22, 1'b0); m_step(8'h22, 1, 0, 1); expect_state("t5_recover_staged");
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t5_recover_commit");

        // Data byte in the same cycle as period_end with an earlier write pending
        send_byte(8'hA0, 1'b0); m_step(8'hA0, 1, 0, 1);
        send_byte(8'h33, 1'b0); m_step(8'h33, 1, 0, 1);
        send_byte(8'hA1, 1'b0); m_step(8'hA1, 1, 0, 1);
        send_byte(8'h20, 1'b1); m_step(8'h20, 1, 1, 1); expect_state("t6_same_cycle_pending_kept");
        pulse_pe(); m_step(8'h00, 0, 1, 1); expect_state("t6_second_commit");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 6) begin
                if (!m_busy && $urandom_range(0, 4) != 0) b = {4'hA, 4'($urandom_range(0, 15))};
                else b = 8'($urandom_range(0, 255));
                pe = ($urandom_range(0, 4) == 0);
                send_byte(b, pe);
                m_step(b, 1, pe, 1);
            end else if (op <= 8) begin
                pulse_pe();
                m_step(8'h00, 0, 1, 1);
            end else begin
                b   = 8'($urandom_range(0, 255));
                ena = 1'b0;
                send_byte(b, 1'b0);
                m_step(b, 1, 0, 0);
                ena = 1'b1;
                tick();
            end
            expect_state($sformatf("rand%0d", n));
        end

        // Reset in the middle of a transaction
        send_byte(8'hA2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_reset();
        expect_state("reset_mid_transaction");
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
